// File: rtl/snake_pio_pkg.sv
// snake_pio_pkg
//   Shared definitions for the snake game's Avalon-MM PIO peripherals:
//   register offsets, the default debounce length and a constant-safe
//   clog2 helper used to size counters.
package snake_pio_pkg;

    // Register offsets (word addresses on the 2-bit Avalon address bus)
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    // 10 ms of stability at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : snake_pio_pkg

// File: rtl/snake_key_debounce.sv
// snake_key_debounce
//   One key bit: two-flop synchroniser followed by a stability counter.
//   The debounced output only follows the synchronised input after it has
//   differed from the current debounced value for DEBOUNCE_CYCLES
//   consecutive cycles; any return to the old value restarts the count.
//   DEBOUNCE_CYCLES = 0 turns the filter into a plain register stage.
//
// Ports
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   raw       : asynchronous key level (0 = pressed)
//   debounced : filtered key level
module snake_key_debounce
    import snake_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic debounced
);

    logic s1_reg;
    logic s2_reg;
    logic db_reg;

    // Synchroniser: raw -> s1 -> s2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg <= RESET_LEVEL;
            s2_reg <= RESET_LEVEL;
        end else begin
            s1_reg <= raw;
            s2_reg <= s1_reg;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    db_reg <= RESET_LEVEL;
                end else begin
                    db_reg <= s2_reg;
                end
            end
        end else begin : g_count
            // Sized for DEBOUNCE_CYCLES; the count is cleared at
            // DEBOUNCE_CYCLES-1, so it can never wrap.
            localparam int CNT_W_RAW = clog2(DEBOUNCE_CYCLES + 1);
            localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             db_next;

            always_comb begin
                cnt_next = '0;
                db_next  = db_reg;
                if (s2_reg != db_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        // Stable long enough: accept the new level
                        db_next  = s2_reg;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                    db_reg  <= RESET_LEVEL;
                end else begin
                    cnt_reg <= cnt_next;
                    db_reg  <= db_next;
                end
            end
        end
    endgenerate

    assign debounced = db_reg;

endmodule : snake_key_debounce

// File: rtl/snake_key_pio.sv
// snake_key_pio
//   Avalon-MM input PIO for the snake game pushbuttons. Each key is
//   synchronised and debounced, falling edges (presses) are latched in
//   EDGECAPTURE, and a registered level interrupt is raised when any
//   captured bit is enabled in IRQMASK.
//
//   Register map (zero wait states, readdata combinational on address):
//     0 DATA        RO   debounced key levels
//     1 (reserved)       reads 0, writes ignored
//     2 IRQMASK     RW   per-key interrupt enable
//     3 EDGECAPTURE W1C  latched presses; a new press wins over a clear
//
// Ports
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   address    : register select
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   in_port    : raw key levels, 0 = pressed
//   readdata   : read data, zero-extended
//   irq        : level interrupt request, active high
module snake_key_pio
    import snake_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edgecap_reg;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] irqmask_reg;
    logic [WIDTH-1:0] irqmask_next;
    logic             irq_reg;
    logic             wr_en;

    // Only the low WIDTH bits of writedata carry register content
    logic unused_writedata;
    if (WIDTH < 32) begin : g_unused_wd
        assign unused_writedata = ^writedata[31:WIDTH];
    end else begin : g_no_unused_wd
        assign unused_writedata = 1'b0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_key
            snake_key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_LEVEL     (RESET_LEVEL[gi])
            ) u_debounce (
                .clk       (clk),
                .reset_n   (reset_n),
                .raw       (in_port[gi]),
                .debounced (debounced[gi])
            );
        end
    endgenerate

    assign wr_en = chipselect && !write_n;

    // prev starts at RESET_LEVEL like the debounced state, so leaving reset
    // never produces an edge by itself.
    assign fall = prev_reg & ~debounced;

    always_comb begin
        irqmask_next = irqmask_reg;
        edgecap_next = edgecap_reg;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask_next = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGECAP)) begin
            edgecap_next = edgecap_reg & ~writedata[WIDTH-1:0];
        end
        // Setting after clearing makes a simultaneous press survive the W1C
        edgecap_next = edgecap_next | fall;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg    <= RESET_LEVEL;
            edgecap_reg <= '0;
            irqmask_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            prev_reg    <= debounced;
            edgecap_reg <= edgecap_next;
            irqmask_reg <= irqmask_next;
            // Registered from current state, so it trails register changes
            // by one cycle.
            irq_reg     <= |(edgecap_reg & irqmask_reg);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = debounced;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_reg;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_reg;
            default:      readdata = '0;
        endcase
    end

    assign irq = irq_reg;

endmodule : snake_key_pio

// File: tb/tb_snake_key_pio.sv
module tb_snake_key_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks;
    int errors;

    snake_key_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .RESET_LEVEL     (4'hF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 ns after the last one
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
        $display("check %-16s observed %h expected %h", tag, observed, expected);
    endtask

    task automatic read_check(input logic [1:0] addr, input string tag, input logic [31:0] expected);
        address = addr;
        #1;
        check(tag, readdata, expected);
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        $display("write addr %0d data %h", addr, data);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        // 1. Reset
        step(3);
        reset_n = 1'b1;
        step(2);
        read_check(2'd0, "rst_data", 32'hF);
        read_check(2'd2, "rst_mask", 32'h0);
        read_check(2'd3, "rst_edgecap", 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);

        // 2. Clean press of key1: DATA after 6 edges, capture 1 later
        in_port = 4'hD;
        step(5);
        read_check(2'd0, "press_data_early", 32'hF);
        step(1);
        read_check(2'd0, "press_data", 32'hD);
        read_check(2'd3, "press_cap_early", 32'h0);
        step(1);
        read_check(2'd3, "press_cap", 32'h2);
        check("press_irq_mask0", {31'd0, irq}, 32'h0);
        step(1);
        check("press_irq_mask0b", {31'd0, irq}, 32'h0);
        bus_write(2'd3, 32'h2);
        read_check(2'd3, "w1c_clear", 32'h0);

        // 3. Bounce on key0, then a stable press
        in_port = 4'hC; step(2);
        in_port = 4'hD; step(2);
        in_port = 4'hC; step(2);
        in_port = 4'hD; step(2);
        read_check(2'd0, "bounce_data", 32'hD);
        read_check(2'd3, "bounce_cap", 32'h0);
        in_port = 4'hC;
        step(5);
        read_check(2'd0, "bounce_hold_early", 32'hD);
        step(1);
        read_check(2'd0, "bounce_hold_data", 32'hC);
        read_check(2'd3, "bounce_cap_early", 32'h0);
        step(1);
        read_check(2'd3, "bounce_cap_once", 32'h1);
        step(4);
        read_check(2'd3, "bounce_cap_later", 32'h1);
        bus_write(2'd3, 32'h1);
        read_check(2'd3, "bounce_cleared", 32'h0);

        // 4. Interrupt path; release of key1 is not captured
        bus_write(2'd2, 32'h2);
        read_check(2'd2, "mask_rd", 32'h2);
        in_port = 4'hE;
        step(8);
        read_check(2'd0, "release_data", 32'hE);
        read_check(2'd3, "release_no_cap", 32'h0);
        in_port = 4'hC;
        step(6);
        read_check(2'd0, "repress_data", 32'hC);
        step(1);
        read_check(2'd3, "repress_cap", 32'h2);
        check("irq_not_yet", {31'd0, irq}, 32'h0);
        step(1);
        check("irq_set", {31'd0, irq}, 32'h1);
        bus_write(2'd3, 32'h1);
        read_check(2'd3, "w1c_other_bit", 32'h2);
        check("irq_held", {31'd0, irq}, 32'h1);
        bus_write(2'd3, 32'h2);
        read_check(2'd3, "w1c_bit1", 32'h0);
        check("irq_lag", {31'd0, irq}, 32'h1);
        step(1);
        check("irq_dropped", {31'd0, irq}, 32'h0);

        // 5. Set/clear collision on key2
        in_port = 4'h8;
        step(6);
        read_check(2'd0, "k2_data", 32'h8);
        read_check(2'd3, "k2_cap_early", 32'h0);
        bus_write(2'd3, 32'h4);
        read_check(2'd3, "collision_set_wins", 32'h4);
        bus_write(2'd3, 32'h4);
        read_check(2'd3, "collision_cleared", 32'h0);
        check("k2_irq_masked", {31'd0, irq}, 32'h0);
        bus_write(2'd1, 32'hFF);
        read_check(2'd1, "reserved_rd", 32'h0);
        bus_write(2'd0, 32'h0);
        read_check(2'd0, "data_ro", 32'h8);

        // 6. Reset in the middle of a press count
        bus_write(2'd2, 32'hF);
        in_port = 4'h0;
        step(8);
        read_check(2'd3, "k3_cap", 32'h8);
        check("k3_irq", {31'd0, irq}, 32'h1);
        in_port = 4'h8;
        step(8);
        read_check(2'd0, "k3_release", 32'h8);
        in_port = 4'h0;
        step(3);
        reset_n = 1'b0;
        #1;
        read_check(2'd0, "midrst_data", 32'hF);
        read_check(2'd2, "midrst_mask", 32'h0);
        read_check(2'd3, "midrst_cap", 32'h0);
        check("midrst_irq", {31'd0, irq}, 32'h0);
        step(2);
        reset_n = 1'b1;
        // Keys held through reset: full debounce again, then counted as a press
        step(5);
        read_check(2'd0, "boot_data_early", 32'hF);
        step(1);
        read_check(2'd0, "boot_data", 32'h0);
        read_check(2'd3, "boot_cap_early", 32'h0);
        step(1);
        read_check(2'd3, "boot_cap", 32'hF);
        step(1);
        check("boot_irq_masked", {31'd0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_snake_key_pio
